arc4_crack_ctrl: RTL
====================

Name: arc4_crack_ctrl

Overview:
Top-level sequencer for ARC4 key search. Per candidate key it runs the init, ksa and prga sub-blocks in order over their en/rdy handshakes, arbitrating the single S-memory port between them. It then scans plaintext memory for printability and either reports the key or advances to the next candidate. It sits between the crack top and the init/ksa/prga instances plus the S and PT RAMs (synchronous, 1-cycle read latency).

Parameters:
KEY_LAST, 24'hFFFFFF, final key tried before declaring failure
PRINT_LO, 8'h20, lowest accepted plaintext byte
PRINT_HI, 8'h7E, highest accepted plaintext byte

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
en  in  1  start request, honoured only while rdy=1
rdy  out  1  idle/done flag
key_start  in  24  first candidate key, latched on accepted en
key_out  out  24  found key, valid when rdy=1 and key_valid=1
key_valid  out  1  1 = key found, 0 = search exhausted
cur_key  out  24  candidate key driven to ksa and prga
init_en / ksa_en / prga_en  out  1 each  one-cycle start pulses
init_rdy / ksa_rdy / prga_rdy  in  1 each  sub-block ready
init_s_addr, init_s_wrdata / ksa_s_addr, ksa_s_wrdata / prga_s_addr, prga_s_wrdata  in  8 each  requester S-memory address/data
init_s_wren / ksa_s_wren / prga_s_wren  in  1 each  requester S write enables
s_addr, s_wrdata  out  8  muxed S-memory port
s_wren  out  1  muxed S write enable
prga_pt_addr, prga_pt_wrdata  in  8  prga PT-memory port
prga_pt_wren  in  1  prga PT write enable
pt_addr, pt_wrdata  out  8  muxed PT-memory port
pt_wren  out  1  muxed PT write enable
pt_rddata  in  8  PT read data

Behaviour:
- Reset (rst=1 at posedge): state IDLE; rdy=1, key_valid=0, key_out=0, cur_key=0, all *_en=0. Outputs s_wren=0 and pt_wren=0 (combinational from IDLE). Sub-blocks reset independently.
- States:
  - IDLE: wait for en.
  - Per sub-block X in {INIT, KSA, PRGA}: X_GO -> X_LO -> X_HI.
  - CHK_LEN -> CHK_LEN_W -> CHK_RD -> CHK_RD_W -> CHK_CMP.
  - NEXT, then back to IDLE.
- IDLE: en=1 and rdy=1 -> cur_key<=key_start, rdy<=0, key_valid<=0, go INIT_GO. en while rdy=0 is ignored.
- X_GO: X_en=1 for exactly one cycle, go X_LO.
- X_LO: wait for X_rdy=0.
- X_HI: wait for X_rdy=1; then INIT->KSA_GO, KSA->PRGA_GO, PRGA->CHK_LEN. No timeout.
- Arbitration (combinational from registered state):
  - INIT_* states: S port = init_* signals.
  - KSA_* states: S port = ksa_*.
  - PRGA_* states: S port = prga_*, PT port = prga_pt_*.
  - CHK_* states: controller owns PT, pt_wren=0.
  - Elsewhere: s_addr=0, s_wrdata=0, s_wren=0 (same for PT).
  - Non-granted requester inputs are ignored entirely.
- Check:
  - CHK_LEN: pt_addr=0.
  - CHK_LEN_W: latch len=pt_rddata, idx<=1.
  - len=0 -> key accepted.
  - Otherwise CHK_RD drives pt_addr=idx; CHK_RD_W waits one cycle; CHK_CMP tests PRINT_LO<=pt_rddata<=PRINT_HI.
  - Byte out of range -> NEXT immediately (early abort).
  - Byte in range with idx==len -> accept; else idx<=idx+1 and go to CHK_RD.
  - idx is 9 bits so len=255 terminates.
- Accept: key_out<=cur_key, key_valid<=1, rdy<=1, go IDLE.
- NEXT:
  - cur_key==KEY_LAST -> key_valid<=0, rdy<=1, go IDLE.
  - Else cur_key<=cur_key+1 (mod 2^24, 24'hFFFFFF wraps to 0), go INIT_GO.
  - If key_start>KEY_LAST, the search wraps through 0 until it reaches KEY_LAST.
- cur_key is stable from INIT_GO through NEXT.
- Reset mid-operation: next cycle is IDLE with reset values. Any in-flight sub-block is abandoned; its rdy is not awaited.

Optional Feature:
ARC4_CRACK_STATS_EN:
- Defined: adds output keys_tried[24:0]. Cleared on reset and on accepted en; incremented once per completed CHK (accept or reject). Holds its value while rdy=1.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 one cycle mid-KSA -> next cycle rdy=1, key_valid=0, ksa_en=0, s_wren=0, pt_wren=0.
- Search hit: behavioural sub-block models, key_start=0, PT check passes only for key 24'h000018 -> rdy=1, key_valid=1, key_out=24'h000018, exactly 25 init_en pulses (keys_tried=25 with STATS).
- Exhaustion: KEY_LAST=24'h000003, key_start=0, never printable -> rdy=1, key_valid=0 after 4 attempts; cur_key=3.
- Arbitration: hold ksa_s_wren=1, ksa_s_addr=8'hAA throughout -> during INIT_* s_wren/s_addr follow init_* only; during KSA_* s_addr=8'hAA; during CHK_* pt_wren=0 despite prga_pt_wren=1.
- Check bounds:
  - PT={3,8'h20,8'h7E,8'h41} -> accepted.
  - PT={3,8'h20,8'h7F,...} -> rejected after reading byte 2 (no read of byte 3).
  - PT={0} -> accepted on first key.
  - PT={1,8'h1F} -> rejected.
- Wrap/handshake: key_start=24'hFFFFFF, KEY_LAST=24'h000001, no hits -> keys tried FFFFFF, 000000, 000001. en pulsed while rdy=0 -> no restart. Each *_en is high exactly one cycle per attempt.

Source files
------------

// File: rtl/arc4_crack_ctrl.sv
// ARC4 key-search sequencer. For each candidate key it runs init, ksa and
// prga over their en/rdy handshakes, owns arbitration of the shared S-memory
// and PT-memory ports, then scans the decrypted plaintext for printable bytes.
// The search ends when a key is accepted or when KEY_LAST has been tried.
// Optional build macro: ARC4_CRACK_STATS_EN adds the keys_tried counter port.
module arc4_crack_ctrl #(
  parameter logic [23:0] KEY_LAST = 24'hFFFFFF,
  parameter logic [7:0]  PRINT_LO = 8'h20,
  parameter logic [7:0]  PRINT_HI = 8'h7E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key_start,
  output logic [23:0] key_out,
  output logic        key_valid,
  output logic [23:0] cur_key,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  input  logic [7:0]  init_s_addr,
  input  logic [7:0]  init_s_wrdata,
  input  logic        init_s_wren,
  input  logic [7:0]  ksa_s_addr,
  input  logic [7:0]  ksa_s_wrdata,
  input  logic        ksa_s_wren,
  input  logic [7:0]  prga_s_addr,
  input  logic [7:0]  prga_s_wrdata,
  input  logic        prga_s_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  input  logic [7:0]  prga_pt_addr,
  input  logic [7:0]  prga_pt_wrdata,
  input  logic        prga_pt_wren,
  output logic [7:0]  pt_addr,
  output logic [7:0]  pt_wrdata,
  output logic        pt_wren,
  input  logic [7:0]  pt_rddata
`ifdef ARC4_CRACK_STATS_EN
  ,
  output logic [24:0] keys_tried
`endif
);

  typedef enum logic [3:0] {
    IDLE,
    INIT_GO, INIT_LO, INIT_HI,
    KSA_GO,  KSA_LO,  KSA_HI,
    PRGA_GO, PRGA_LO, PRGA_HI,
    CHK_LEN, CHK_LEN_W, CHK_RD, CHK_RD_W, CHK_CMP,
    NEXT
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  len;
  logic [8:0]  idx;   // one bit wider than len so len=255 still terminates

  logic start, accept, give_up, advance, len_ld, idx_inc, chk_done;

  function automatic logic printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic, start pulses and datapath strobes
  always_comb begin
    state_nx = state;
    init_en  = 1'b0;
    ksa_en   = 1'b0;
    prga_en  = 1'b0;
    start    = 1'b0;
    accept   = 1'b0;
    give_up  = 1'b0;
    advance  = 1'b0;
    len_ld   = 1'b0;
    idx_inc  = 1'b0;
    chk_done = 1'b0;
    case (state)
      IDLE:      if (en && rdy) begin start = 1'b1; state_nx = INIT_GO; end
      INIT_GO:   begin init_en = 1'b1; state_nx = INIT_LO; end
      INIT_LO:   if (!init_rdy) state_nx = INIT_HI;
      INIT_HI:   if (init_rdy)  state_nx = KSA_GO;
      KSA_GO:    begin ksa_en = 1'b1; state_nx = KSA_LO; end
      KSA_LO:    if (!ksa_rdy) state_nx = KSA_HI;
      KSA_HI:    if (ksa_rdy)  state_nx = PRGA_GO;
      PRGA_GO:   begin prga_en = 1'b1; state_nx = PRGA_LO; end
      PRGA_LO:   if (!prga_rdy) state_nx = PRGA_HI;
      PRGA_HI:   if (prga_rdy)  state_nx = CHK_LEN;
      CHK_LEN:   state_nx = CHK_LEN_W;
      CHK_LEN_W: begin
        len_ld = 1'b1;
        if (pt_rddata == 8'd0) begin
          accept   = 1'b1;
          chk_done = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = CHK_RD;
        end
      end
      CHK_RD:    state_nx = CHK_RD_W;
      CHK_RD_W:  state_nx = CHK_CMP;
      CHK_CMP: begin
        if (!printable(pt_rddata)) begin
          chk_done = 1'b1;
          state_nx = NEXT;
        end else if (idx == {1'b0, len}) begin
          accept   = 1'b1;
          chk_done = 1'b1;
          state_nx = IDLE;
        end else begin
          idx_inc  = 1'b1;
          state_nx = CHK_RD;
        end
      end
      NEXT: begin
        if (cur_key == KEY_LAST) begin
          give_up  = 1'b1;
          state_nx = IDLE;
        end else begin
          advance  = 1'b1;
          state_nx = INIT_GO;
        end
      end
      default:   state_nx = IDLE;
    endcase
  end

  // Memory-port arbitration: the grant follows the registered state only
  always_comb begin
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (state)
      INIT_GO, INIT_LO, INIT_HI: begin
        s_addr   = init_s_addr;
        s_wrdata = init_s_wrdata;
        s_wren   = init_s_wren;
      end
      KSA_GO, KSA_LO, KSA_HI: begin
        s_addr   = ksa_s_addr;
        s_wrdata = ksa_s_wrdata;
        s_wren   = ksa_s_wren;
      end
      PRGA_GO, PRGA_LO, PRGA_HI: begin
        s_addr    = prga_s_addr;
        s_wrdata  = prga_s_wrdata;
        s_wren    = prga_s_wren;
        pt_addr   = prga_pt_addr;
        pt_wrdata = prga_pt_wrdata;
        pt_wren   = prga_pt_wren;
      end
      // Address is held through the wait and compare so the RAM output stays
      // on the byte being tested; CHK_LEN/CHK_LEN_W read address 0.
      CHK_RD, CHK_RD_W, CHK_CMP: pt_addr = idx[7:0];
      default: ;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy       <= 1'b1;
      key_valid <= 1'b0;
      key_out   <= 24'd0;
      cur_key   <= 24'd0;
    end else begin
      if (start) begin
        cur_key   <= key_start;
        rdy       <= 1'b0;
        key_valid <= 1'b0;
      end
      if (accept) begin
        key_out   <= cur_key;
        key_valid <= 1'b1;
        rdy       <= 1'b1;
      end
      if (give_up) begin
        key_valid <= 1'b0;
        rdy       <= 1'b1;
      end
      if (advance) cur_key <= cur_key + 24'd1;
    end
  end

  // Plaintext scan length and byte index (always written before use)
  always_ff @(posedge clk) begin
    if (len_ld) begin
      len <= pt_rddata;
      idx <= 9'd1;
    end else if (idx_inc) begin
      idx <= idx + 9'd1;
    end
  end

`ifdef ARC4_CRACK_STATS_EN
  // Count of candidate keys whose plaintext check has completed
  always_ff @(posedge clk) begin
    if (rst || start) keys_tried <= 25'd0;
    else if (chk_done) keys_tried <= keys_tried + 25'd1;
  end
`endif

endmodule
